// File: rtl/axi_resp_pkg.sv
// Shared constants and FSM state types for the AXI burst responder.
package axi_resp_pkg;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] AXI_SIZE_64B   = 3'd6;
   localparam int         BEAT_BYTES     = 64;
   localparam int         BEAT_SHIFT     = $clog2(BEAT_BYTES);

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
   typedef enum logic       {R_IDLE, R_BURST}         rd_state_t;
endpackage

// File: rtl/axi_resp_ram.sv
// Simple dual-port RAM, byte-enable write port, registered read port.
module axi_resp_ram #(
   parameter int DATA_WIDTH = 512,
   parameter int ADDR_BITS  = 10
) (
   input  logic                    clk_i,
   input  logic                    we_i,
   input  logic [ADDR_BITS-1:0]    waddr_i,
   input  logic [DATA_WIDTH/8-1:0] wstrb_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   input  logic                    re_i,
   input  logic [ADDR_BITS-1:0]    raddr_i,
   output logic [DATA_WIDTH-1:0]   rdata_o
);
   localparam int NB    = DATA_WIDTH / 8;
   localparam int DEPTH = 1 << ADDR_BITS;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   // No reset on the array or read register so the tools can map this to BRAM.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int b = 0; b < NB; b++) begin
            if (wstrb_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
         end
      end
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/axi_burst_responder.sv
// AXI4 INCR burst slave backed by on-chip RAM; independent write and read FSMs
// share one simple dual-port RAM. Protocol violations bump a saturating counter.
module axi_burst_responder
   import axi_resp_pkg::*;
#(
   parameter int DATA_WIDTH     = 512,
   parameter int ADDR_WIDTH     = 32,
   parameter int MEM_DEPTH_LOG2 = 10,
   parameter int ERR_WIDTH      = 16
) (
   input  logic                    axi_clk,
   input  logic                    axi_aresetn,
   input  logic [ADDR_WIDTH-1:0]   axi_awaddr,
   input  logic [7:0]              axi_awlen,
   input  logic [2:0]              axi_awsize,
   input  logic [1:0]              axi_awburst,
   input  logic                    axi_awvalid,
   output logic                    axi_awready,
   input  logic [DATA_WIDTH-1:0]   axi_wdata,
   input  logic [DATA_WIDTH/8-1:0] axi_wstrb,
   input  logic                    axi_wlast,
   input  logic                    axi_wvalid,
   output logic                    axi_wready,
   output logic                    axi_bvalid,
   input  logic                    axi_bready,
   input  logic [ADDR_WIDTH-1:0]   axi_araddr,
   input  logic [7:0]              axi_arlen,
   input  logic [2:0]              axi_arsize,
   input  logic [1:0]              axi_arburst,
   input  logic                    axi_arvalid,
   output logic                    axi_arready,
   output logic [DATA_WIDTH-1:0]   axi_rdata,
   output logic                    axi_rlast,
   output logic                    axi_rvalid,
   input  logic                    axi_rready,
   output logic [ERR_WIDTH-1:0]    err_count
);
   localparam int IW  = MEM_DEPTH_LOG2;
   localparam int EW1 = ERR_WIDTH + 1;

   // ---------------- write side ----------------
   wr_state_t       w_state_q, w_state_d;
   logic [IW-1:0]   w_idx_q, w_idx_d;
   logic [7:0]      w_cnt_q, w_cnt_d;   // beats remaining after the current one
   logic            aw_hs, w_hs, w_final;

   assign axi_awready = (w_state_q == W_IDLE);
   assign axi_wready  = (w_state_q == W_DATA);
   assign axi_bvalid  = (w_state_q == W_RESP);
   assign aw_hs       = axi_awvalid && axi_awready;
   assign w_hs        = axi_wvalid && axi_wready;
   assign w_final     = (w_cnt_q == 8'd0);

   always_comb begin
      w_state_d = w_state_q;
      w_idx_d   = w_idx_q;
      w_cnt_d   = w_cnt_q;
      case (w_state_q)
         W_IDLE: if (aw_hs) begin
            w_idx_d   = axi_awaddr[IW+BEAT_SHIFT-1:BEAT_SHIFT];
            w_cnt_d   = axi_awlen;
            w_state_d = W_DATA;
         end
         W_DATA: if (w_hs) begin
            // Beat count, not wlast, closes the burst.
            w_idx_d = w_idx_q + IW'(1);
            w_cnt_d = w_cnt_q - 8'd1;
            if (w_final) w_state_d = W_RESP;
         end
         W_RESP: if (axi_bready) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge axi_clk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         w_state_q <= W_IDLE;
         w_idx_q   <= '0;
         w_cnt_q   <= '0;
      end else begin
         w_state_q <= w_state_d;
         w_idx_q   <= w_idx_d;
         w_cnt_q   <= w_cnt_d;
      end
   end

   // ---------------- read side ----------------
   rd_state_t             r_state_q, r_state_d;
   logic [IW-1:0]         r_idx_q, r_idx_d;     // next word to fetch
   logic [7:0]            r_len_q, r_len_d;
   logic [8:0]            r_fetch_q, r_fetch_d; // beats fetched so far
   logic                  r_infl_q, r_infl_last_q;
   logic [1:0]            r_cnt_q;
   logic [DATA_WIDTH-1:0] r_buf0_q, r_buf1_q;
   logic                  r_last0_q, r_last1_q;
   logic                  ar_hs, r_hs, r_issue, r_issue_last;
   logic [IW-1:0]         r_raddr;
   logic [1:0]            r_occ;
   logic [DATA_WIDTH-1:0] ram_rdata;

   assign axi_arready = (r_state_q == R_IDLE);
   assign axi_rvalid  = (r_cnt_q != 2'd0);
   assign axi_rdata   = r_buf0_q;
   assign axi_rlast   = axi_rvalid && r_last0_q;
   assign ar_hs       = axi_arvalid && axi_arready;
   assign r_hs        = axi_rvalid && axi_rready;
   // Occupancy after this cycle's pop, so a stream with rready high never bubbles.
   assign r_occ       = r_cnt_q + 2'(r_infl_q) - 2'(r_hs);

   always_comb begin
      r_state_d    = r_state_q;
      r_idx_d      = r_idx_q;
      r_len_d      = r_len_q;
      r_fetch_d    = r_fetch_q;
      r_issue      = 1'b0;
      r_issue_last = 1'b0;
      r_raddr      = r_idx_q;
      case (r_state_q)
         R_IDLE: if (ar_hs) begin
            // Fetch beat 0 straight off the AR bus to hit the 2-cycle first-beat latency.
            r_issue      = 1'b1;
            r_raddr      = axi_araddr[IW+BEAT_SHIFT-1:BEAT_SHIFT];
            r_issue_last = (axi_arlen == 8'd0);
            r_idx_d      = r_raddr + IW'(1);
            r_len_d      = axi_arlen;
            r_fetch_d    = 9'd1;
            r_state_d    = R_BURST;
         end
         R_BURST: begin
            if (r_occ < 2'd2 && r_fetch_q <= {1'b0, r_len_q}) begin
               r_issue      = 1'b1;
               r_issue_last = (r_fetch_q[7:0] == r_len_q);
               r_idx_d      = r_idx_q + IW'(1);
               r_fetch_d    = r_fetch_q + 9'd1;
            end
            if (r_hs && axi_rlast) r_state_d = R_IDLE;
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge axi_clk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         r_state_q     <= R_IDLE;
         r_idx_q       <= '0;
         r_len_q       <= '0;
         r_fetch_q     <= '0;
         r_infl_q      <= 1'b0;
         r_infl_last_q <= 1'b0;
         r_cnt_q       <= '0;
         r_buf0_q      <= '0;
         r_buf1_q      <= '0;
         r_last0_q     <= 1'b0;
         r_last1_q     <= 1'b0;
      end else begin
         r_state_q     <= r_state_d;
         r_idx_q       <= r_idx_d;
         r_len_q       <= r_len_d;
         r_fetch_q     <= r_fetch_d;
         r_infl_q      <= r_issue;
         r_infl_last_q <= r_issue_last;
         r_cnt_q       <= r_cnt_q + 2'(r_infl_q) - 2'(r_hs);
         if (r_hs) begin
            if (r_infl_q && r_cnt_q == 2'd1) begin
               r_buf0_q  <= ram_rdata;
               r_last0_q <= r_infl_last_q;
            end else begin
               r_buf0_q  <= r_buf1_q;
               r_last0_q <= r_last1_q;
            end
            if (r_infl_q) begin
               r_buf1_q  <= ram_rdata;
               r_last1_q <= r_infl_last_q;
            end
         end else if (r_infl_q) begin
            if (r_cnt_q == 2'd0) begin
               r_buf0_q  <= ram_rdata;
               r_last0_q <= r_infl_last_q;
            end else begin
               r_buf1_q  <= ram_rdata;
               r_last1_q <= r_infl_last_q;
            end
         end
      end
   end

   axi_resp_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_BITS  (IW)
   ) u_ram (
      .clk_i   (axi_clk),
      .we_i    (w_hs),
      .waddr_i (w_idx_q),
      .wstrb_i (axi_wstrb),
      .wdata_i (axi_wdata),
      .re_i    (r_issue),
      .raddr_i (r_raddr),
      .rdata_o (ram_rdata)
   );

   // ---------------- protocol error counter ----------------
   logic                 aw_err, ar_err, w_err;
   logic [1:0]           err_sum;
   logic [EW1-1:0]       err_ext;
   logic [ERR_WIDTH-1:0] err_q, err_d;

   assign aw_err  = aw_hs && (axi_awburst != AXI_BURST_INCR || axi_awsize != AXI_SIZE_64B);
   assign ar_err  = ar_hs && (axi_arburst != AXI_BURST_INCR || axi_arsize != AXI_SIZE_64B);
   assign w_err   = w_hs && (axi_wlast != w_final);
   assign err_sum = 2'(aw_err) + 2'(w_err) + 2'(ar_err);
   assign err_ext = {1'b0, err_q} + EW1'(err_sum);
   assign err_d   = err_ext[ERR_WIDTH] ? '1 : err_ext[ERR_WIDTH-1:0];
   assign err_count = err_q;

   always_ff @(posedge axi_clk or negedge axi_aresetn) begin
      if (!axi_aresetn) err_q <= '0;
      else              err_q <= err_d;
   end

   logic unused_addr_bits;
   assign unused_addr_bits = ^{axi_awaddr[ADDR_WIDTH-1:IW+BEAT_SHIFT], axi_awaddr[BEAT_SHIFT-1:0],
                               axi_araddr[ADDR_WIDTH-1:IW+BEAT_SHIFT], axi_araddr[BEAT_SHIFT-1:0]};
endmodule

// File: tb/tb_axi_burst_responder.sv
// Directed self-checking bench for axi_burst_responder.
module tb_axi_burst_responder;
   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic [31:0]  awaddr = '0, araddr = '0;
   logic [7:0]   awlen = '0, arlen = '0;
   logic [2:0]   awsize = 3'd6, arsize = 3'd6;
   logic [1:0]   awburst = 2'b01, arburst = 2'b01;
   logic         awvalid = 0, wvalid = 0, wlast = 0, bready = 0, arvalid = 0, rready = 0;
   logic [511:0] wdata = '0;
   logic [63:0]  wstrb = '0;
   logic         awready, wready, bvalid, arready, rvalid, rlast;
   logic [511:0] rdata;
   logic [15:0]  errc;

   always #5 clk = ~clk;

   axi_burst_responder dut (
      .axi_clk(clk), .axi_aresetn(rstn),
      .axi_awaddr(awaddr), .axi_awlen(awlen), .axi_awsize(awsize), .axi_awburst(awburst),
      .axi_awvalid(awvalid), .axi_awready(awready),
      .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wlast(wlast), .axi_wvalid(wvalid), .axi_wready(wready),
      .axi_bvalid(bvalid), .axi_bready(bready),
      .axi_araddr(araddr), .axi_arlen(arlen), .axi_arsize(arsize), .axi_arburst(arburst),
      .axi_arvalid(arvalid), .axi_arready(arready),
      .axi_rdata(rdata), .axi_rlast(rlast), .axi_rvalid(rvalid), .axi_rready(rready),
      .err_count(errc)
   );

   int n_tests = 0, n_fail = 0;
   logic [511:0] wbeats [256];
   logic [63:0]  wstrbs [256];
   logic [511:0] rbeats [256];
   logic         rlasts [256];
   int nbeats, rd_lat, stall_viol, gaps, b_early, ar_back, r_after;
   logic b_next;

   task automatic step();
      @(posedge clk); #2;
   endtask

   task automatic write_burst(input logic [31:0] addr, input int len, input logic [1:0] burst,
                              input logic [2:0] size, input int bad_last);
      int to;
      b_early = 0; b_next = 0;
      awaddr = addr; awlen = 8'(len); awburst = burst; awsize = size; awvalid = 1;
      to = 0;
      while (!awready && to < 50) begin step(); to++; end
      if (!awready) begin
         n_tests++; n_fail++; $display("FAIL aw_timeout: awready=0, required 1"); awvalid = 0; return;
      end
      step(); awvalid = 0;
      for (int i = 0; i <= len; i++) begin
         wdata = wbeats[i]; wstrb = wstrbs[i];
         wlast = (bad_last < 0) ? (i == len) : (i == bad_last);
         wvalid = 1; to = 0;
         while (!wready && to < 50) begin step(); to++; end
         if (!wready) begin
            n_tests++; n_fail++; $display("FAIL w_timeout: wready=0 at beat %0d, required 1", i);
            wvalid = 0; return;
         end
         if (bvalid) b_early++;
         step();
      end
      wvalid = 0; wlast = 0;
      b_next = bvalid;
      bready = 1; to = 0;
      while (!bvalid && to < 50) begin step(); to++; end
      if (!bvalid) begin
         n_tests++; n_fail++; $display("FAIL b_timeout: bvalid=0, required 1"); bready = 0; return;
      end
      step(); bready = 0;
   endtask

   task automatic read_burst(input logic [31:0] addr, input int len, input logic [1:0] burst,
                             input logic [2:0] size, input int rmode);
      int to;
      logic stalled, pl;
      logic [511:0] pd;
      nbeats = 0; stall_viol = 0; gaps = 0; rd_lat = 0; ar_back = 0; r_after = 1;
      araddr = addr; arlen = 8'(len); arburst = burst; arsize = size; arvalid = 1;
      to = 0;
      while (!arready && to < 50) begin step(); to++; end
      if (!arready) begin
         n_tests++; n_fail++; $display("FAIL ar_timeout: arready=0, required 1"); arvalid = 0; return;
      end
      step(); arvalid = 0;
      rd_lat = 1;
      while (!rvalid && rd_lat < 20) begin step(); rd_lat++; end
      if (!rvalid) begin
         n_tests++; n_fail++; $display("FAIL r_timeout: rvalid=0, required 1"); return;
      end
      stalled = 0; pd = '0; pl = 0; to = 0;
      while (nbeats <= len && to < 3000) begin
         rready = (rmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
         if (stalled && (rdata !== pd || rlast !== pl || rvalid !== 1'b1)) stall_viol++;
         if (rvalid) begin
            if (rready) begin rbeats[nbeats] = rdata; rlasts[nbeats] = rlast; nbeats++; end
         end else if (rmode == 0) gaps++;
         stalled = rvalid && !rready; pd = rdata; pl = rlast;
         if (rvalid && rready && rlast) begin step(); break; end
         step(); to++;
      end
      rready = 0;
      ar_back = int'(arready);
      r_after = int'(rvalid);
   endtask

   task automatic test_reset();
      rstn = 0; step(); step();
      n_tests++; if (awready !== 1'b1) begin n_fail++; $display("FAIL rst_awready: got %b, required 1", awready); end
      n_tests++; if (arready !== 1'b1) begin n_fail++; $display("FAIL rst_arready: got %b, required 1", arready); end
      n_tests++; if (wready !== 1'b0) begin n_fail++; $display("FAIL rst_wready: got %b, required 0", wready); end
      n_tests++; if (bvalid !== 1'b0) begin n_fail++; $display("FAIL rst_bvalid: got %b, required 0", bvalid); end
      n_tests++; if (rvalid !== 1'b0 || rlast !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid_rlast: got %b%b, required 00", rvalid, rlast); end
      n_tests++; if (rdata !== 512'd0) begin n_fail++; $display("FAIL rst_rdata: got %h, required 0", rdata); end
      n_tests++; if (errc !== 16'd0) begin n_fail++; $display("FAIL rst_err: got %0d, required 0", errc); end
      rstn = 1; step();
   endtask

   task automatic test_single_beat();
      logic [511:0] exp;
      exp = {64{8'hA5}};
      wbeats[0] = exp; wstrbs[0] = '1;
      write_burst(32'h40, 0, 2'b01, 3'd6, -1);
      n_tests++; if (b_next !== 1'b1 || b_early != 0) begin n_fail++; $display("FAIL single_bvalid: got next=%b early=%0d, required 1/0", b_next, b_early); end
      read_burst(32'h40, 0, 2'b01, 3'd6, 0);
      n_tests++; if (rd_lat != 2) begin n_fail++; $display("FAIL single_latency: got %0d, required 2", rd_lat); end
      n_tests++; if (nbeats != 1 || rbeats[0] !== exp) begin n_fail++; $display("FAIL single_data: got n=%0d %h, required 1 %h", nbeats, rbeats[0], exp); end
      n_tests++; if (rlasts[0] !== 1'b1) begin n_fail++; $display("FAIL single_rlast: got %b, required 1", rlasts[0]); end
      n_tests++; if (ar_back != 1 || r_after != 0) begin n_fail++; $display("FAIL single_return: got arready=%0d rvalid=%0d, required 1/0", ar_back, r_after); end
   endtask

   task automatic test_full_burst();
      for (int i = 0; i < 256; i++) begin wbeats[i] = 512'(i); wstrbs[i] = '1; end
      write_burst(32'h0, 255, 2'b01, 3'd6, -1);
      n_tests++; if (b_next !== 1'b1 || b_early != 0) begin n_fail++; $display("FAIL full_bvalid: got next=%b early=%0d, required 1/0", b_next, b_early); end
      read_burst(32'h0, 255, 2'b01, 3'd6, 0);
      n_tests++; if (nbeats != 256) begin n_fail++; $display("FAIL full_count: got %0d, required 256", nbeats); end
      n_tests++; if (gaps != 0 || rd_lat != 2) begin n_fail++; $display("FAIL full_stream: got gaps=%0d lat=%0d, required 0/2", gaps, rd_lat); end
      for (int i = 0; i < nbeats; i++) begin
         n_tests++;
         if (rbeats[i] !== 512'(i) || rlasts[i] !== (i == 255)) begin
            n_fail++; $display("FAIL full_beat%0d: got data=%0h last=%b, required %0h/%b", i, rbeats[i], rlasts[i], i, (i == 255));
         end
      end
      n_tests++; if (errc !== 16'd0) begin n_fail++; $display("FAIL full_err: got %0d, required 0", errc); end
   endtask

   task automatic test_strobes();
      logic [511:0] exp;
      exp = {{60{8'hFF}}, 32'h0};
      wbeats[0] = '1; wstrbs[0] = '1;
      write_burst(32'h140, 0, 2'b01, 3'd6, -1);
      wbeats[0] = '0; wstrbs[0] = 64'hF;
      write_burst(32'h140, 0, 2'b01, 3'd6, -1);
      read_burst(32'h140, 0, 2'b01, 3'd6, 0);
      n_tests++; if (nbeats != 1 || rbeats[0] !== exp) begin n_fail++; $display("FAIL strobe_data: got %h, required %h", rbeats[0], exp); end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 4; i++) begin wbeats[i] = 512'(32'hB000 + i); wstrbs[i] = '1; end
      write_burst(32'hFF80, 3, 2'b01, 3'd6, -1);
      read_burst(32'h0, 0, 2'b01, 3'd6, 0);
      n_tests++; if (rbeats[0] !== 512'hB002) begin n_fail++; $display("FAIL wrap_word0: got %0h, required b002", rbeats[0]); end
      read_burst(32'h10040, 0, 2'b01, 3'd6, 0);
      n_tests++; if (rbeats[0] !== 512'hB003) begin n_fail++; $display("FAIL wrap_alias: got %0h, required b003", rbeats[0]); end
      read_burst(32'hFF80, 3, 2'b01, 3'd6, 0);
      n_tests++; if (nbeats != 4) begin n_fail++; $display("FAIL wrap_count: got %0d, required 4", nbeats); end
      for (int i = 0; i < nbeats; i++) begin
         n_tests++;
         if (rbeats[i] !== 512'(32'hB000 + i)) begin n_fail++; $display("FAIL wrap_beat%0d: got %0h, required %0h", i, rbeats[i], 32'hB000 + i); end
      end
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < 16; i++) begin wbeats[i] = {16{32'(i * 7 + 1)}}; wstrbs[i] = '1; end
      write_burst(32'h1900, 15, 2'b01, 3'd6, -1);
      read_burst(32'h1900, 15, 2'b01, 3'd6, 1);
      n_tests++; if (nbeats != 16) begin n_fail++; $display("FAIL bp_count: got %0d, required 16", nbeats); end
      n_tests++; if (stall_viol != 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable stalls, required 0", stall_viol); end
      for (int i = 0; i < nbeats; i++) begin
         n_tests++;
         if (rbeats[i] !== {16{32'(i * 7 + 1)}} || rlasts[i] !== (i == 15)) begin
            n_fail++; $display("FAIL bp_beat%0d: got %0h last=%b, required %0h last=%b", i, rbeats[i][31:0], rlasts[i], i * 7 + 1, (i == 15));
         end
      end
   endtask

   task automatic test_errors();
      wbeats[0] = 512'hE0; wbeats[1] = 512'hE1; wstrbs[0] = '1; wstrbs[1] = '1;
      write_burst(32'h2000, 1, 2'b10, 3'd5, -1);
      n_tests++; if (errc !== 16'd1 || b_next !== 1'b1) begin n_fail++; $display("FAIL err_aw: got err=%0d b=%b, required 1/1", errc, b_next); end
      read_burst(32'h2000, 1, 2'b01, 3'd6, 0);
      n_tests++; if (nbeats != 2 || rbeats[0] !== 512'hE0 || rbeats[1] !== 512'hE1) begin n_fail++; $display("FAIL err_aw_serviced: got n=%0d %0h %0h, required 2 e0 e1", nbeats, rbeats[0], rbeats[1]); end
      for (int i = 0; i < 4; i++) begin wbeats[i] = 512'(32'hD0 + i); wstrbs[i] = '1; end
      write_burst(32'h2100, 3, 2'b01, 3'd6, 1);
      n_tests++; if (errc !== 16'd3) begin n_fail++; $display("FAIL err_wlast: got %0d, required 3", errc); end
      n_tests++; if (b_early != 0 || b_next !== 1'b1) begin n_fail++; $display("FAIL err_wlast_b: got early=%0d next=%b, required 0/1", b_early, b_next); end
      read_burst(32'h2000, 0, 2'b01, 3'd5, 0);
      n_tests++; if (errc !== 16'd4 || rbeats[0] !== 512'hE0) begin n_fail++; $display("FAIL err_ar: got err=%0d data=%0h, required 4 e0", errc, rbeats[0]); end
   endtask

   task automatic test_reset_midread();
      int to;
      araddr = 32'h0; arlen = 8'd15; arburst = 2'b01; arsize = 3'd6; arvalid = 1; rready = 0;
      step(); arvalid = 0;
      to = 0;
      while (!rvalid && to < 10) begin step(); to++; end
      n_tests++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_rvalid: got %b, required 1", rvalid); end
      #1 rstn = 0;
      #1;
      n_tests++; if (rvalid !== 1'b0 || rlast !== 1'b0) begin n_fail++; $display("FAIL mid_rvalid: got %b%b, required 00", rvalid, rlast); end
      n_tests++; if (errc !== 16'd0) begin n_fail++; $display("FAIL mid_err: got %0d, required 0", errc); end
      step(); step(); rstn = 1; step();
      n_tests++; if (arready !== 1'b1 || awready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got ar=%b aw=%b, required 1/1", arready, awready); end
      read_burst(32'h40, 0, 2'b01, 3'd6, 0);
      n_tests++; if (nbeats != 1 || rbeats[0] !== 512'hB003) begin n_fail++; $display("FAIL mid_ram_kept: got %0h, required b003", rbeats[0]); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_beat();
      test_full_burst();
      test_strobes();
      test_wrap();
      test_backpressure();
      test_errors();
      test_reset_midread();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
